// File: rtl/microwave_pkg.sv
// Shared encodings and constants for the microwave cooking timer.
package microwave_pkg;

    localparam int unsigned DIGIT_W        = 4;
    localparam int unsigned STATE_W        = 3;
    localparam int unsigned BEEP_W         = 4;
    localparam int unsigned BEEP_TICKS_DEF = 3;

    localparam logic [DIGIT_W-1:0] DIGIT_MAX    = 4'd9;
    localparam logic [DIGIT_W-1:0] SEC_TENS_MAX = 4'd5;
    localparam logic [DIGIT_W-1:0] KEY_MAX      = 4'd9;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE  = 3'd0,
        ST_ENTRY = 3'd1,
        ST_COOK  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD down-counting digit with parallel load; wraps 0 -> MAXV and borrows.
module bcd_down_digit
    import microwave_pkg::*;
#(
    parameter logic [DIGIT_W-1:0] MAXV = DIGIT_MAX
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               load,
    input  logic [DIGIT_W-1:0] d,
    input  logic               en,
    output logic [DIGIT_W-1:0] q,
    output logic               borrow
);

    assign borrow = en && (q == '0);

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end else if (en) begin
            q <= (q == '0) ? MAXV : q - DIGIT_W'(1);
        end
    end

endmodule

// File: rtl/microwave_timer_ctrl.sv
// Cooking-timer sequencer: keypad entry, MM:SS countdown, magnetron gating and end beep.
module microwave_timer_ctrl
    import microwave_pkg::*;
#(
    parameter int unsigned BEEP_TICKS = BEEP_TICKS_DEF
) (
    input  logic               clk,
    input  logic               clrn,
    input  logic               tick,
    input  logic               key_valid,
    input  logic [DIGIT_W-1:0] key_data,
    input  logic               start,
    input  logic               stop,
    input  logic               clear,
    input  logic               door_closed,
    output logic [DIGIT_W-1:0] mm_tens,
    output logic [DIGIT_W-1:0] mm_ones,
    output logic [DIGIT_W-1:0] ss_tens,
    output logic [DIGIT_W-1:0] ss_ones,
    output logic               mag_on,
    output logic               beep,
    output logic               done,
    output logic               err,
    output logic [STATE_W-1:0] state
);

    state_t              st_q, st_d;
    logic [BEEP_W-1:0]   bcnt_q, bcnt_d;
    logic                mag_d, beep_d, done_d, err_d;
    logic                zero_ld, shift_ld, dec_en;
    logic                dig_ld;
    logic                b_so, b_st, b_mo, b_mt;
    logic                key_ok, time_zero, time_one;

    assign state     = st_q;
    assign key_ok    = key_valid && (key_data <= KEY_MAX);
    assign time_zero = (mm_tens == '0) && (mm_ones == '0) && (ss_tens == '0) && (ss_ones == '0);
    assign time_one  = (mm_tens == '0) && (mm_ones == '0) && (ss_tens == '0)
                       && (ss_ones == DIGIT_W'(1));
    assign dig_ld    = zero_ld || shift_ld;

    // Digit chain: parallel load for entry shift / zeroing, borrow cascade for countdown.
    bcd_down_digit #(.MAXV(DIGIT_MAX)) u_ss_ones (
        .clk(clk), .clrn(clrn), .load(dig_ld), .d(shift_ld ? key_data : '0),
        .en(dec_en), .q(ss_ones), .borrow(b_so)
    );
    bcd_down_digit #(.MAXV(SEC_TENS_MAX)) u_ss_tens (
        .clk(clk), .clrn(clrn), .load(dig_ld), .d(shift_ld ? ss_ones : '0),
        .en(b_so), .q(ss_tens), .borrow(b_st)
    );
    bcd_down_digit #(.MAXV(DIGIT_MAX)) u_mm_ones (
        .clk(clk), .clrn(clrn), .load(dig_ld), .d(shift_ld ? ss_tens : '0),
        .en(b_st), .q(mm_ones), .borrow(b_mo)
    );
    bcd_down_digit #(.MAXV(DIGIT_MAX)) u_mm_tens (
        .clk(clk), .clrn(clrn), .load(dig_ld), .d(shift_ld ? mm_ones : '0),
        .en(b_mo), .q(mm_tens), .borrow(b_mt)
    );

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            st_q   <= ST_IDLE;
            bcnt_q <= '0;
            mag_on <= 1'b0;
            beep   <= 1'b0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            st_q   <= st_d;
            bcnt_q <= bcnt_d;
            mag_on <= mag_d;
            beep   <= beep_d;
            done   <= done_d;
            err    <= err_d;
        end
    end

    // Event priority per state: clear > stop > door open > start > key > tick.
    always_comb begin
        st_d     = st_q;
        bcnt_d   = bcnt_q;
        zero_ld  = 1'b0;
        shift_ld = 1'b0;
        dec_en   = 1'b0;
        done_d   = 1'b0;
        err_d    = 1'b0;
        unique case (st_q)
            ST_IDLE: begin
                if (!clear && key_ok) begin
                    shift_ld = 1'b1;
                    st_d     = ST_ENTRY;
                end
            end
            ST_ENTRY: begin
                if (clear || stop) begin
                    zero_ld = 1'b1;
                    st_d    = ST_IDLE;
                end else if (start) begin
                    if (ss_tens > SEC_TENS_MAX) begin
                        err_d = 1'b1;
                    end else if (door_closed && !time_zero) begin
                        st_d = ST_COOK;
                    end
                end else if (key_ok) begin
                    shift_ld = 1'b1;
                end
            end
            ST_COOK: begin
                if (clear) begin
                    zero_ld = 1'b1;
                    st_d    = ST_IDLE;
                end else if (stop || !door_closed) begin
                    st_d = ST_PAUSE;
                end else if (tick) begin
                    dec_en = 1'b1;
                    if (time_one) begin
                        st_d   = ST_DONE;
                        done_d = 1'b1;
                        bcnt_d = BEEP_W'(BEEP_TICKS);
                    end
                end
            end
            ST_PAUSE: begin
                if (clear || stop) begin
                    zero_ld = 1'b1;
                    st_d    = ST_IDLE;
                end else if (start && door_closed) begin
                    st_d = ST_COOK;
                end
            end
            ST_DONE: begin
                if (clear || stop || start || key_valid) begin
                    st_d   = ST_IDLE;
                    bcnt_d = '0;
                end else if (tick) begin
                    bcnt_d = bcnt_q - BEEP_W'(1);
                    if (bcnt_q == BEEP_W'(1)) begin
                        st_d = ST_IDLE;
                    end
                end
            end
            default: begin
                zero_ld = 1'b1;
                st_d    = ST_IDLE;
            end
        endcase
        mag_d  = (st_d == ST_COOK);
        beep_d = (st_d == ST_DONE);
    end

endmodule

// File: tb/tb_microwave_timer_ctrl.sv
// Bench for microwave_timer_ctrl: directed vector table, corner sequences, random vs. seconds-based model.
module tb_microwave_timer_ctrl;

    logic       clk = 1'b0;
    logic       clrn;
    logic       tick, key_valid, start, stop, clear, door_closed;
    logic [3:0] key_data;
    logic [3:0] mm_tens, mm_ones, ss_tens, ss_ones;
    logic       mag_on, beep, done, err;
    logic [2:0] state;

    int tests = 0;
    int fails = 0;

    microwave_timer_ctrl dut (
        .clk(clk), .clrn(clrn), .tick(tick), .key_valid(key_valid), .key_data(key_data),
        .start(start), .stop(stop), .clear(clear), .door_closed(door_closed),
        .mm_tens(mm_tens), .mm_ones(mm_ones), .ss_tens(ss_tens), .ss_ones(ss_ones),
        .mag_on(mag_on), .beep(beep), .done(done), .err(err), .state(state)
    );

    always #5 clk = ~clk;

    localparam int M_IDLE = 0, M_ENTRY = 1, M_COOK = 2, M_PAUSE = 3, M_DONE = 4;
    localparam int BEEP_N = 3;

    // Reference model: time kept as four entered digits, countdown done in whole seconds.
    int m_st;
    int dg[4];
    int m_bcnt;
    bit m_mag, m_beep, m_done, m_err;

    function automatic int to_secs();
        return (dg[0] * 10 + dg[1]) * 60 + dg[2] * 10 + dg[3];
    endfunction

    task automatic from_secs(input int s);
        dg[0] = s / 600;
        dg[1] = (s / 60) % 10;
        dg[2] = (s % 60) / 10;
        dg[3] = s % 10;
    endtask

    task automatic model_reset();
        m_st = M_IDLE; m_bcnt = 0;
        for (int i = 0; i < 4; i++) dg[i] = 0;
        m_mag = 0; m_beep = 0; m_done = 0; m_err = 0;
    endtask

    task automatic shift_in(input int k);
        for (int i = 0; i < 3; i++) dg[i] = dg[i + 1];
        dg[3] = k;
    endtask

    task automatic go_idle();
        m_st = M_IDLE;
        for (int i = 0; i < 4; i++) dg[i] = 0;
    endtask

    task automatic model_step();
        int s;
        bit kok;
        kok = key_valid && (key_data <= 4'd9);
        m_done = 0; m_err = 0;
        case (m_st)
            M_IDLE: if (!clear && kok) begin shift_in(int'(key_data)); m_st = M_ENTRY; end
            M_ENTRY: begin
                if (clear || stop) go_idle();
                else if (start) begin
                    if (dg[2] > 5) m_err = 1;
                    else if (door_closed && to_secs() != 0) m_st = M_COOK;
                end else if (kok) shift_in(int'(key_data));
            end
            M_COOK: begin
                if (clear) go_idle();
                else if (stop || !door_closed) m_st = M_PAUSE;
                else if (tick) begin
                    s = to_secs() - 1;
                    from_secs(s);
                    if (s == 0) begin m_st = M_DONE; m_done = 1; m_bcnt = BEEP_N; end
                end
            end
            M_PAUSE: begin
                if (clear || stop) go_idle();
                else if (start && door_closed) m_st = M_COOK;
            end
            M_DONE: begin
                if (clear || stop || start || key_valid) m_st = M_IDLE;
                else if (tick) begin
                    m_bcnt--;
                    if (m_bcnt == 0) m_st = M_IDLE;
                end
            end
            default: go_idle();
        endcase
        m_mag  = (m_st == M_COOK);
        m_beep = (m_st == M_DONE);
    endtask

    function automatic logic [22:0] dut_vec();
        return {state, mm_tens, mm_ones, ss_tens, ss_ones, mag_on, beep, done, err};
    endfunction

    function automatic logic [22:0] model_vec();
        return {3'(m_st), 4'(dg[0]), 4'(dg[1]), 4'(dg[2]), 4'(dg[3]), m_mag, m_beep, m_done, m_err};
    endfunction

    task automatic check(input string name, input logic [22:0] got, input logic [22:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got st/time/mag/beep/done/err=%h required %h", name, got, exp);
        end
    endtask

    task automatic set_in(input bit c, input bit p, input bit s, input bit t,
                          input bit kv, input int key, input bit door);
        clear = c; stop = p; start = s; tick = t; key_valid = kv;
        key_data = 4'(key); door_closed = door;
    endtask

    task automatic release_pulses();
        clear = 0; stop = 0; start = 0; tick = 0; key_valid = 0; key_data = 4'd0;
    endtask

    // Advance one clock: model consumes the same inputs, DUT is sampled 1 ns after the edge.
    task automatic step(input string name);
        model_step();
        @(posedge clk);
        #1;
        check(name, dut_vec(), model_vec());
        release_pulses();
    endtask

    task automatic key(input int k);
        set_in(0, 0, 0, 0, 1, k, door_closed);
        step("key");
    endtask

    typedef struct {
        bit c, p, s, t, kv;
        int key;
        bit door;
        int est;
        logic [15:0] etime;
        bit mag, bp, dn, er;
    } vec_t;

    vec_t vq[$];

    task automatic add(input bit c, input bit p, input bit s, input bit t, input bit kv,
                       input int key, input bit door, input int est, input logic [15:0] etime,
                       input bit mag, input bit bp, input bit dn, input bit er);
        vec_t v;
        v.c = c; v.p = p; v.s = s; v.t = t; v.kv = kv; v.key = key; v.door = door;
        v.est = est; v.etime = etime; v.mag = mag; v.bp = bp; v.dn = dn; v.er = er;
        vq.push_back(v);
    endtask

    initial begin
        //  c  p  s  t kv key door  st  time      mag bp dn er
        add(0, 0, 0, 0, 1, 1, 1,   1, 16'h0001, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 1,   1, 16'h0013, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1,   1, 16'h0130, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1,   2, 16'h0130, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   2, 16'h0129, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   2, 16'h0128, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   2, 16'h0127, 1, 0, 0, 0);
        add(0, 0, 0, 0, 0, 0, 0,   3, 16'h0127, 0, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,   3, 16'h0127, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 0,   3, 16'h0127, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1,   2, 16'h0127, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 0,   3, 16'h0127, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1,   2, 16'h0127, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   2, 16'h0126, 1, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1,   3, 16'h0126, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1,   0, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 12, 1,  0, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1,   1, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1,   1, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 7, 1,   1, 16'h0007, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 5, 1,   1, 16'h0075, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1,   1, 16'h0075, 0, 0, 0, 1);
        add(0, 0, 0, 0, 0, 0, 1,   1, 16'h0075, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1,   1, 16'h0750, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1,   1, 16'h7500, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 4, 1,   1, 16'h5004, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 5, 1,   1, 16'h0045, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1,   2, 16'h0045, 1, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1,   0, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 2, 1,   1, 16'h0002, 0, 0, 0, 0);
        add(1, 0, 1, 0, 0, 0, 1,   0, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 2, 1,   1, 16'h0002, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1,   2, 16'h0002, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   2, 16'h0001, 1, 0, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   4, 16'h0000, 0, 1, 1, 0);
        add(0, 0, 0, 0, 0, 0, 1,   4, 16'h0000, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   4, 16'h0000, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   4, 16'h0000, 0, 1, 0, 0);
        add(0, 0, 0, 1, 0, 0, 1,   0, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 0, 1,   1, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 0, 1,   1, 16'h0000, 0, 0, 0, 0);
        add(0, 0, 0, 0, 1, 3, 1,   1, 16'h0003, 0, 0, 0, 0);
        add(0, 1, 0, 0, 0, 0, 1,   0, 16'h0000, 0, 0, 0, 0);

        clrn = 1'b0;
        release_pulses();
        door_closed = 1'b1;
        model_reset();
        #12;
        check("reset", dut_vec(), 23'd0);
        clrn = 1'b1;

        // Directed table, checked against its own expected columns.
        foreach (vq[i]) begin
            set_in(vq[i].c, vq[i].p, vq[i].s, vq[i].t, vq[i].kv, vq[i].key, vq[i].door);
            model_step();
            @(posedge clk);
            #1;
            check($sformatf("vec%0d", i), dut_vec(),
                  {3'(vq[i].est), vq[i].etime, vq[i].mag, vq[i].bp, vq[i].dn, vq[i].er});
            release_pulses();
        end

        // 01:00 -> 00:59 and 10:00 -> 09:59 borrow chains.
        door_closed = 1;
        key(0); key(1); key(0); key(0);
        set_in(0, 0, 1, 0, 0, 0, 1); step("start_0100");
        set_in(0, 0, 0, 1, 0, 0, 1); step("tick_0100");
        check("borrow_0100", {mm_tens, mm_ones, ss_tens, ss_ones}, 16'h0059);
        set_in(1, 0, 0, 0, 0, 0, 1); step("clr");
        key(1); key(0); key(0); key(0);
        set_in(0, 0, 1, 0, 0, 0, 1); step("start_1000");
        set_in(0, 0, 0, 1, 0, 0, 1); step("tick_1000");
        check("borrow_1000", {mm_tens, mm_ones, ss_tens, ss_ones}, 16'h0959);
        set_in(1, 0, 0, 0, 0, 0, 1); step("clr");

        // Key in DONE aborts the beep and is not captured.
        key(1);
        set_in(0, 0, 1, 0, 0, 0, 1); step("start_0001");
        set_in(0, 0, 0, 1, 0, 0, 1); step("tick_to_done");
        key(5);
        check("done_key_abort", dut_vec(), 23'd0);
        step("idle_after_abort");
        check("done_key_not_captured", dut_vec(), 23'd0);

        // Asynchronous reset in the middle of a cook.
        key(5);
        set_in(0, 0, 1, 0, 0, 0, 1); step("start_0005");
        set_in(0, 0, 0, 1, 0, 0, 1); step("tick_0005");
        @(posedge clk);
        #3 clrn = 1'b0;
        #1 check("async_reset", dut_vec(), 23'd0);
        model_reset();
        @(negedge clk);
        clrn = 1'b1;

        // Random single-event traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            int r;
            int k;
            bit door;
            door = door_closed;
            if ($urandom_range(0, 19) == 0) door = ~door;
            r = $urandom_range(0, 19);
            k = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 2) : $urandom_range(0, 15);
            case (r)
                0:       set_in(1, 0, 0, 0, 0, 0, door);
                1:       set_in(0, 1, 0, 0, 0, 0, door);
                2, 3:    set_in(0, 0, 1, 0, 0, 0, door);
                4, 5, 6: set_in(0, 0, 0, 0, 1, k, door);
                7, 8, 9, 10, 11, 12, 13: set_in(0, 0, 0, 1, 0, 0, door);
                default: set_in(0, 0, 0, 0, 0, 0, door);
            endcase
            step($sformatf("rand%0d", n));
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
